// File: rtl/pwm_capture.sv
// Measures PWM duty, rising edges and stuck state over windows of 2^WIN_BITS clocks; results appear the cycle after the window's last clock.
// No backpressure. Optional glitch filter on the synchronised input: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
   parameter int WIN_BITS    = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pwm_in,
   output logic       level,
   output logic [7:0] duty,
   output logic [7:0] edges,
   output logic       stuck,
   output logic       duty_valid
);

   if (WIN_BITS < 8 || SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
      $error("pwm_capture: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   f;

   always_ff @(posedge clock) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [FCW-1:0] flt_cnt;
   logic           f_q;

   // f follows s only once s has differed from f for FILTER_LEN consecutive cycles
   always_ff @(posedge clock) begin
      if (reset) begin
         flt_cnt <= '0;
         f_q     <= 1'b0;
      end else if (s == f_q) begin
         flt_cnt <= '0;
      end else if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
         f_q     <= s;
         flt_cnt <= '0;
      end else begin
         flt_cnt <= flt_cnt + 1'b1;
      end
   end

   assign f = f_q;
`else
   assign f = s;
`endif

   assign level = f;

   logic [WIN_BITS-1:0] win_cnt;
   logic [WIN_BITS:0]   hi_acc;
   logic [WIN_BITS:0]   total;
   logic [7:0]          edge_cnt;
   logic [7:0]          edge_next;
   logic                any_edge;
   logic                any_next;
   logic                f_d;
   logic                rise;

   localparam logic [WIN_BITS:0] FULL = {1'b1, {WIN_BITS{1'b0}}};

   // Closing values include the current cycle's sample and edge
   always_comb begin
      rise      = f & ~f_d;
      total     = hi_acc + {{WIN_BITS{1'b0}}, f};
      edge_next = (rise && edge_cnt != 8'hFF) ? edge_cnt + 8'd1 : edge_cnt;
      any_next  = any_edge | (f ^ f_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         win_cnt    <= '0;
         hi_acc     <= '0;
         edge_cnt   <= '0;
         any_edge   <= 1'b0;
         f_d        <= 1'b0;
         duty       <= '0;
         edges      <= '0;
         stuck      <= 1'b0;
         duty_valid <= 1'b0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
         f_d     <= f;
         if (&win_cnt) begin
            duty       <= (total == FULL) ? 8'hFF : total[WIN_BITS-1 -: 8];
            edges      <= edge_next;
            stuck      <= ~any_next;
            duty_valid <= 1'b1;
            hi_acc     <= '0;
            edge_cnt   <= '0;
            any_edge   <= 1'b0;
         end else begin
            hi_acc     <= total;
            edge_cnt   <= edge_next;
            any_edge   <= any_next;
            duty_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: an 8-bit window instance for most scenarios and a 10-bit window instance for the fast-toggle case.
module tb_pwm_capture;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset   = 1'b1;
   logic       pwm_in  = 1'b0;
   logic       reset_b = 1'b1;
   logic       pwm_b   = 1'b0;

   logic       level, stuck, duty_valid;
   logic [7:0] duty, edges;
   logic       level_b, stuck_b, duty_valid_b;
   logic [7:0] duty_b, edges_b;

   pwm_capture #(.WIN_BITS(8), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
      .clock(clock), .reset(reset), .pwm_in(pwm_in), .level(level),
      .duty(duty), .edges(edges), .stuck(stuck), .duty_valid(duty_valid)
   );

   pwm_capture #(.WIN_BITS(10), .SYNC_STAGES(2), .FILTER_LEN(4)) dut_b (
      .clock(clock), .reset(reset_b), .pwm_in(pwm_b), .level(level_b),
      .duty(duty_b), .edges(edges_b), .stuck(stuck_b), .duty_valid(duty_valid_b)
   );

   int   checks = 0;
   int   errors = 0;
   int   mode   = 0;
   int   ph     = 0;
   logic lvl_or = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: inputs change on the falling edge, outputs are sampled there too
   task automatic step();
      @(negedge clock);
      ph++;
      case (mode)
         0: pwm_in = 1'b0;
         1: pwm_in = 1'b1;
         2: pwm_in = ((ph % 16) < 4) ? 1'b1 : 1'b0;
         default: pwm_in = ((ph % 32) < 2) ? 1'b1 : 1'b0;
      endcase
      pwm_b  = ~pwm_b;
      lvl_or = lvl_or | level;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) step();
      reset = 1'b0;
   endtask

   // Returns the number of cycles until duty_valid, or -1 on timeout
   task automatic wait_valid(input bit sel_b, input int maxc, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      while (n < maxc) begin
         step();
         n++;
         if (sel_b ? duty_valid_b : duty_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) n = -1;
   endtask

   initial begin
      int n;

      // Held low after reset
      mode = 0;
      repeat (4) step();
      check("rst_duty",  32'(duty), 32'h00);
      check("rst_edges", 32'(edges), 32'h00);
      check("rst_stuck", 32'(stuck), 32'h0);
      check("rst_valid", 32'(duty_valid), 32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rstb_duty", 32'(duty_b), 32'h00);
      reset  = 1'b0;
      lvl_or = 1'b0;
      wait_valid(1'b0, 300, n);
      check("low_cycle", 32'(n), 32'd256);
      check("low_duty",  32'(duty), 32'h00);
      check("low_edges", 32'(edges), 32'h00);
      check("low_stuck", 32'(stuck), 32'h1);
      step();
      check("low_pulse", 32'(duty_valid), 32'h0);
      check("low_hold",  32'(stuck), 32'h1);
      check("low_level", 32'(lvl_or), 32'h0);

      // Held high across reset
      mode = 1;
      do_reset(4);
      wait_valid(1'b0, 300, n);
      check("hi1_cycle", 32'(n), 32'd256);
      check("hi1_duty",  32'(duty), 32'hFE);
      check("hi1_edges", 32'(edges), 32'h01);
      check("hi1_stuck", 32'(stuck), 32'h0);
      wait_valid(1'b0, 300, n);
      check("hi2_cycle", 32'(n), 32'd256);
      check("hi2_duty",  32'(duty), 32'hFF);
      check("hi2_edges", 32'(edges), 32'h00);
      check("hi2_stuck", 32'(stuck), 32'h1);
      check("hi_level",  32'(level), 32'h1);

      // Square wave, period 16, 4 high
      mode = 2;
      do_reset(4);
      wait_valid(1'b0, 300, n);
      wait_valid(1'b0, 300, n);
      check("sq2_cycle", 32'(n), 32'd256);
      check("sq2_duty",  32'(duty), 32'h40);
      check("sq2_edges", 32'(edges), 32'd16);
      check("sq2_stuck", 32'(stuck), 32'h0);
      wait_valid(1'b0, 300, n);
      check("sq3_duty",  32'(duty), 32'h40);
      check("sq3_edges", 32'(edges), 32'd16);

      // Reset pulsed for 3 cycles at cycle 100 of a window
      mode = 1;
      do_reset(4);
      repeat (100) step();
      check("mid_level_before", 32'(level), 32'h1);
      reset = 1'b1;
      repeat (3) step();
      check("mid_duty",  32'(duty), 32'h00);
      check("mid_edges", 32'(edges), 32'h00);
      check("mid_stuck", 32'(stuck), 32'h0);
      check("mid_valid", 32'(duty_valid), 32'h0);
      check("mid_level", 32'(level), 32'h0);
      reset = 1'b0;
      wait_valid(1'b0, 300, n);
      check("mid_cycle", 32'(n), 32'd256);
      check("mid_after_duty", 32'(duty), 32'hFE);

      // 2-cycle glitches, one per 32 cycles
      mode = 3;
      do_reset(4);
      wait_valid(1'b0, 300, n);
      wait_valid(1'b0, 300, n);
      check("gl_cycle", 32'(n), 32'd256);
`ifdef PWM_CAPTURE_FILTER_EN
      check("gl_duty",  32'(duty), 32'h00);
      check("gl_edges", 32'(edges), 32'h00);
      check("gl_stuck", 32'(stuck), 32'h1);
`else
      check("gl_duty",  32'(duty), 32'h10);
      check("gl_edges", 32'(edges), 32'h08);
      check("gl_stuck", 32'(stuck), 32'h0);
`endif

      // 10-bit window, input toggling every cycle
      reset_b = 1'b0;
      wait_valid(1'b1, 1100, n);
      check("tg1_cycle", 32'(n), 32'd1024);
      wait_valid(1'b1, 1100, n);
      check("tg2_cycle", 32'(n), 32'd1024);
      check("tg2_duty",  32'(duty_b), 32'h80);
      check("tg2_edges", 32'(edges_b), 32'hFF);
      check("tg2_stuck", 32'(stuck_b), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the duty cycle of an external PWM signal over fixed windows of 2^WIN_BITS clocks. Produces an 8-bit duty value on the same scale the breathing-LED counters drive into the PWM generators, so 0x00 means always low and 0xFF means always high. Sits at the board input side, for example on a loopback of the LED PWM pin or an external PWM source, and feeds status logic or a display.

## Interface
- WIN_BITS, 16: log2 of the window length in clocks; legal range ≥ 8.
- SYNC_STAGES, 2: length of the input synchroniser; legal range ≥ 2.
- FILTER_LEN, 4: number of consecutive stable samples the glitch filter requires; used only with PWM_CAPTURE_FILTER_EN.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- level  out  1  conditioned input level, called f below.
- duty  out  8  duty of the last completed window.
- edges  out  8  rising edges of f in the last completed window, saturating at 255.
- stuck  out  1  high when the last completed window contained no edge of f in either direction.
- duty_valid  out  1  one-cycle pulse that marks the update of duty, edges and stuck.

## Operation
- Synchroniser: pwm_in passes through SYNC_STAGES flops, all of which reset to 0. Its output is s.
- Conditioning: without the filter, f = s. With the filter, see Configuration.
- Window counter win_cnt:
  - WIN_BITS wide, +1 every cycle.
  - Wraps from all-ones to 0.
- High accumulator hi_acc:
  - WIN_BITS+1 wide, +1 in each cycle where f = 1.
- Edge accumulator:
  - 8 bits, +1 on each rising edge of f; holds at 255.
  - A separate 1-bit flag records whether any edge of f occurred in the window.
- Window close, in the cycle where win_cnt is all ones:
  - total = hi_acc + f, so it includes the current cycle.
  - duty is loaded with 8'hFF if total = 2^WIN_BITS. Otherwise duty = total[WIN_BITS-1:WIN_BITS-8], i.e. truncated, not rounded.
  - edges is loaded with the edge count, including an edge that occurs in that same cycle.
  - stuck is loaded with the inverse of the any-edge flag.
  - duty_valid is set to 1.
  - The accumulators restart from 0, or from the current cycle's contribution; no sample is lost or counted twice.
- Between window closes, duty, edges and stuck hold their values and duty_valid is 0.
- Reset:
  - All registers clear: win_cnt, the accumulators, the synchroniser and the filter.
  - All outputs read 0: duty, edges, stuck, duty_valid and level.
  - Reset asserted mid-window discards the partial window. No duty_valid pulse is produced for it.

## Timing
- Take cycle 0 as the first cycle with reset low. Then win_cnt = 0 in cycle 0 and duty_valid = 1 in cycle 2^WIN_BITS, then every 2^WIN_BITS cycles after that.
- Latency from pwm_in to f is SYNC_STAGES cycles, plus FILTER_LEN cycles with the filter. As a result, the first window after reset counts the reset value 0 for those initial cycles.
- duty, edges and stuck change only in the cycle in which duty_valid = 1, and all three change together.

## Configuration
- PWM_CAPTURE_FILTER_EN defined: a glitch filter sits between s and f.
  - A FILTER_LEN-cycle counter increments while s ≠ f and clears while s = f.
  - When the counter reaches FILTER_LEN-1 with s still ≠ f, f takes the value of s and the counter clears.
  - Pulses of either polarity shorter than FILTER_LEN cycles never reach f.
- PWM_CAPTURE_FILTER_EN undefined: f = s, the filter logic is absent, and FILTER_LEN is ignored.

## Test plan
All scenarios use WIN_BITS = 8 and SYNC_STAGES = 2 unless stated otherwise.
- pwm_in held at 0 after reset -> duty_valid in cycle 256 with duty = 0x00, edges = 0, stuck = 1. level = 0 throughout.
- pwm_in held at 1 across reset -> first window gives duty = 0xFE (the 2 synchroniser cycles read 0), edges = 1, stuck = 0. Second window gives duty = 0xFF (saturated), edges = 0, stuck = 1.
- Square wave with period 16, 4 cycles high, running continuously -> every window from the second onward gives duty = 0x40, edges = 16, stuck = 0.
- Reset pulsed for 3 cycles at cycle 100 -> all outputs 0, and no duty_valid until 256 cycles after reset falls.
- Eight 2-cycle high glitches on an otherwise low line, one per 32-cycle period:
  - Without the macro -> duty = 0x10, edges = 8.
  - With PWM_CAPTURE_FILTER_EN and FILTER_LEN = 4 -> duty = 0x00, edges = 0, stuck = 1.
- WIN_BITS = 10, pwm_in toggling every cycle -> steady-state duty = 0x80, edges = 0xFF (saturated), stuck = 0.
